// File: rtl/mmio_switch_led.sv
// Memory-mapped I/O bridge between the CPU data path and the board switches
// and LEDs. A 16-byte window holds four word registers: SWITCH (debounced
// switch value), LED (read/write), LED_TOGGLE (XOR write) and STATUS (sticky
// switch-change flag, cleared by reading it). Every request takes one cycle
// and is acknowledged by a one-cycle ready pulse on the following cycle.
module mmio_switch_led #(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    SW_WIDTH        = 8,
    parameter int                    LED_WIDTH       = 8,
    parameter logic [DATA_WIDTH-1:0] IO_BASE         = 32'hFFFF_FC00,
    parameter int                    DEBOUNCE_CYCLES = 16,
    parameter logic [LED_WIDTH-1:0]  LED_RESET       = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic                  io_sel,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    input  logic [SW_WIDTH-1:0]   switch,
    output logic [LED_WIDTH-1:0]  led
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    start;
    logic                    do_write;
    logic                    do_read;
    logic [1:0]              reg_sel;
    logic [DATA_WIDTH-1:0]   rd_val;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [LED_WIDTH-1:0]    led_q, led_d;
    logic [SW_WIDTH-1:0]     sync1_q, sync2_q, prev_q;
    logic [SW_WIDTH-1:0]     stable_q, stable_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic                    deb_update;
    logic                    flag_q, flag_d;
    logic                    unused_bits;

    // Byte-lane bits and the LED-unused part of wdata carry no meaning here.
    assign unused_bits = ^{addr[1:0], wdata};

    assign io_sel  = (addr[DATA_WIDTH-1:4] == IO_BASE[DATA_WIDTH-1:4]);
    assign reg_sel = addr[3:2];
    assign ready   = (state_q == RESP);
    assign rdata   = rdata_q;
    assign led     = led_q;

    // Request FSM: accept a windowed request in IDLE, acknowledge it in RESP.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (io_sel && (mem_read || mem_write)) begin
                    state_d = RESP;
                    start   = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A simultaneous read and write is treated as a write only.
    assign do_write = start & mem_write;
    assign do_read  = start & mem_read & ~mem_write;

    // Register read mux; all values zero-extended to the bus width.
    always_comb begin
        rd_val = '0;
        case (reg_sel)
            2'd0:    rd_val[SW_WIDTH-1:0]  = stable_q;
            2'd1:    rd_val[LED_WIDTH-1:0] = led_q;
            2'd3:    rd_val[0]             = flag_q;
            default: rd_val                = '0;
        endcase
    end

    // LED register updates and read-data capture for accepted transactions.
    always_comb begin
        led_d   = led_q;
        rdata_d = rdata_q;
        if (do_write) begin
            if (reg_sel == 2'd1) begin
                led_d = wdata[LED_WIDTH-1:0];
            end else if (reg_sel == 2'd2) begin
                led_d = led_q ^ wdata[LED_WIDTH-1:0];
            end
        end
        if (do_read) begin
            rdata_d = rd_val;
        end
    end

    // Debounce: count cycles the synchronised value has been steady and
    // different from the accepted value; any bounce restarts the count.
    always_comb begin
        cnt_inc    = cnt_q + CNT_W'(1);
        cnt_d      = cnt_q;
        stable_d   = stable_q;
        deb_update = 1'b0;
        if ((sync2_q != prev_q) || (sync2_q == stable_q)) begin
            cnt_d = '0;
        end else if (cnt_inc == CNT_MAX) begin
            stable_d   = sync2_q;
            cnt_d      = '0;
            deb_update = 1'b1;
        end else begin
            cnt_d = cnt_inc;
        end
    end

    // Sticky change flag: a new accepted switch value outranks a STATUS-read clear.
    always_comb begin
        flag_d = flag_q;
        if (do_read && (reg_sel == 2'd3)) begin
            flag_d = 1'b0;
        end
        if (deb_update) begin
            flag_d = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus-facing registers: LED drive and captured read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q   <= LED_RESET;
            rdata_q <= '0;
        end else begin
            led_q   <= led_d;
            rdata_q <= rdata_d;
        end
    end

    // Switch synchroniser, debounce state and change flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
        end else begin
            sync1_q  <= switch;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            flag_q   <= flag_d;
        end
    end

endmodule

// File: doc/mmio_switch_led.md
# mmio_switch_led

Parametrised memory-mapped I/O bridge between the minisys CPU data path and the board switches and LEDs. It decodes a 16-byte I/O window on the CPU data address and serves word reads and writes with a registered request/ready handshake. The switch bank is synchronised and debounced, and a sticky change flag is kept. The LED bank is a writable/toggle register. Switch and LED widths, data width, window base and debounce length are generics, so one block serves every board variant.

## Interface
- DATA_WIDTH, 32, CPU data/address width; must be ≥ max(SW_WIDTH, LED_WIDTH, 5).
- SW_WIDTH, 8, number of switch inputs.
- LED_WIDTH, 8, number of LED outputs.
- IO_BASE, 32'hFFFF_FC00, window base; low 4 bits must be 0.
- DEBOUNCE_CYCLES, 16, stable cycles required before a switch change is accepted; must be ≥ 1.
- LED_RESET, 0, LED value after reset.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- addr  in  DATA_WIDTH  byte address (ALU result).
- wdata  in  DATA_WIDTH  write data.
- mem_read  in  1  read request, held until ready.
- mem_write  in  1  write request, held until ready.
- io_sel  out  1  combinational: addr lies in the window.
- rdata  out  DATA_WIDTH  registered read data.
- ready  out  1  registered one-cycle completion pulse.
- switch  in  SW_WIDTH  raw asynchronous switch pins.
- led  out  LED_WIDTH  registered LED drive.

## Operation
- Window decode: io_sel = (addr[DATA_WIDTH-1:4] == IO_BASE[DATA_WIDTH-1:4]). Register select is addr[3:2]. addr[1:0] is ignored.
- Register map:
  - 0x0 SWITCH, RO: debounced value, zero-extended.
  - 0x4 LED, RW: write loads wdata[LED_WIDTH-1:0]; read returns led zero-extended.
  - 0x8 LED_TOGGLE, WO: led ^= wdata[LED_WIDTH-1:0]; reads as 0.
  - 0xC STATUS: bit0 = change flag, other bits 0; a read clears bit0; writes are ignored.
- FSM with two states, IDLE and RESP.
  - IDLE → RESP when io_sel and (mem_read or mem_write).
  - The side effect (LED update, rdata capture, flag clear) occurs on that same edge.
  - RESP → IDLE unconditionally; ready = 1 only in RESP.
  - A request still asserted in IDLE starts a new transaction.
- If mem_read and mem_write are both set, the write wins: rdata holds, the status flag is not cleared, and ready still pulses.
- Requests with io_sel = 0 are ignored: state stays IDLE, no ready.
- Synchroniser: two flops on switch (sync1 → sync2), plus prev = sync2 delayed one cycle.
- Debounce, with counter width $clog2(DEBOUNCE_CYCLES+1):
  - cnt clears when sync2 != prev or sync2 == stable.
  - Otherwise cnt increments; when it would reach DEBOUNCE_CYCLES, stable <= sync2 and cnt <= 0.
- Change flag: set on any edge where stable updates to a different value. If set and a STATUS-read clear coincide, set wins.

## Timing
- Reset values: led = LED_RESET, rdata = 0, ready = 0, state IDLE, sync1/sync2/prev/stable = 0, cnt = 0, flag = 0.
- Reset mid-transaction aborts the transaction; ready falls asynchronously with rst.
- Read latency: request seen at edge N → rdata valid and ready = 1 after edge N, for exactly one cycle; rdata holds until the next read.
- Write latency: led changes after edge N; ready pulses in the same cycle.
- Throughput: one transaction per 2 cycles.
- Switch latency: a pin change present before edge 1 becomes stable after edge DEBOUNCE_CYCLES+3, provided it does not change again. A bounce restarts the count.
- io_sel has no registered delay.

## Test plan
- Reset with LED_RESET=8'hA5 and ready forced busy → led=8'hA5, ready=0, rdata=0 immediately on rst rise; state resumes IDLE after rst falls.
- Write 0x0000_003C to IO_BASE+4, then toggle with 0x0F at IO_BASE+8 → led=0x3C after the first ready, led=0x33 after the second; each ready is a single-cycle pulse.
- DEBOUNCE_CYCLES=4, switch 0x00→0x81 held → SWITCH reads 0x81 from edge 7 onward, STATUS reads 1 then 0 on the next read; a 3-cycle glitch to 0x81 leaves SWITCH at 0x00 and the flag at 0.
- Hold mem_read on IO_BASE+0 for 6 cycles → ready pulses on 3 cycles (alternating); with addr=IO_BASE-4, io_sel=0 and no ready.
- mem_read and mem_write together on IO_BASE+0xC while the flag=1 → ready pulses, rdata unchanged, flag stays 1; a debounce update coinciding with a STATUS read leaves the flag at 1.
- SW_WIDTH=4, LED_WIDTH=16, DATA_WIDTH=32 → SWITCH read upper 28 bits = 0; LED write 0xFFFF_1234 → led=0x1234.
